// File: rtl/color_mask_bbox_pkg.sv
// ============================================================================
// Module : color_mask_bbox_pkg
// Brief  : Shared defines for the colour-mask pipeline. The optional centroid
//          sums are enabled by defining macro COLOR_MASK_CENTROID_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package color_mask_bbox_pkg;

    localparam int COLOR_WIDTH   = 8;
    localparam int c_DEF_IMG_W   = 640;
    localparam int c_DEF_IMG_H   = 480;
    localparam int c_DEF_MIN_PIX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } bbox_state_t;

endpackage

`default_nettype wire

// File: rtl/color_mask_bbox_if.sv
// ============================================================================
// Module : color_mask_bbox_if
// Brief  : Mask pixel stream in, per-frame bounding-box result out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface color_mask_bbox_if
    import color_mask_bbox_pkg::*;
#(
    parameter int IMG_W = c_DEF_IMG_W,
    parameter int IMG_H = c_DEF_IMG_H
) ();

    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int CNT_W = X_W + Y_W;

    logic                   i_valid;
    logic                   i_sof;
    logic                   i_wb;
    logic                   o_box_valid;
    logic [X_W-1:0]         o_x_min;
    logic [X_W-1:0]         o_x_max;
    logic [Y_W-1:0]         o_y_min;
    logic [Y_W-1:0]         o_y_max;
    logic [CNT_W-1:0]       o_cnt;
    logic                   o_found;
    logic [X_W+CNT_W-1:0]   o_x_sum;
    logic [Y_W+CNT_W-1:0]   o_y_sum;

    modport master (
        output i_valid, i_sof, i_wb,
        input  o_box_valid, o_x_min, o_x_max, o_y_min, o_y_max,
               o_cnt, o_found, o_x_sum, o_y_sum
    );

    modport slave (
        input  i_valid, i_sof, i_wb,
        output o_box_valid, o_x_min, o_x_max, o_y_min, o_y_max,
               o_cnt, o_found, o_x_sum, o_y_sum
    );

endinterface

`default_nettype wire

// File: rtl/color_mask_bbox_pix_xy_cnt.sv
// ============================================================================
// Module : pix_xy_cnt
// Brief  : Raster x/y position of the pixel currently on the stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pix_xy_cnt
    import color_mask_bbox_pkg::*;
#(
    parameter int IMG_W = c_DEF_IMG_W,
    parameter int IMG_H = c_DEF_IMG_H
) (
    input  wire logic                     sys_clk,
    input  wire logic                     sys_rst,
    input  wire logic                     i_valid,
    input  wire logic                     i_sof,
    output logic [$clog2(IMG_W)-1:0]      x,
    output logic [$clog2(IMG_H)-1:0]      y,
    output logic                          last
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] c_X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(IMG_H - 1);

    // r_x/r_y hold the position the next pixel will take; sof overrides it
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    assign x    = i_sof ? '0 : r_x;
    assign y    = i_sof ? '0 : r_y;
    assign last = i_valid && (x == c_X_LAST) && (y == c_Y_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_valid) begin
            if (x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (y == c_Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
                r_x <= x + X_W'(1);
                r_y <= y;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/color_mask_bbox.sv
// ============================================================================
// Module : color_mask_bbox
// Brief  : Per-frame bounding box, pixel count and (with macro
//          COLOR_MASK_CENTROID_EN) coordinate sums of a binary colour mask.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_mask_bbox
    import color_mask_bbox_pkg::*;
#(
    parameter int IMG_W   = c_DEF_IMG_W,
    parameter int IMG_H   = c_DEF_IMG_H,
    parameter int MIN_PIX = c_DEF_MIN_PIX
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    color_mask_bbox_if.slave  bus
);

    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int CNT_W = X_W + Y_W;
    localparam int XS_W  = X_W + CNT_W;
    localparam int YS_W  = Y_W + CNT_W;
    localparam logic [31:0] c_MIN_PIX = 32'(MIN_PIX);

    bbox_state_t      r_state, w_state_n;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_last, w_pix, w_new, w_first, w_found;

    logic [X_W-1:0]   r_x_min, r_x_max, w_x_min_n, w_x_max_n;
    logic [Y_W-1:0]   r_y_min, r_y_max, w_y_min_n, w_y_max_n;
    // One spare bit: a full power-of-two frame holds 2**CNT_W pixels
    logic [CNT_W:0]   r_cnt, w_cnt_n, w_cnt_base;
    logic [CNT_W-1:0] w_cnt_sat;

    logic [X_W-1:0]   r_res_x_min, r_res_x_max;
    logic [Y_W-1:0]   r_res_y_min, r_res_y_max;
    logic [CNT_W-1:0] r_res_cnt;
    logic             r_res_found;

    pix_xy_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_xy (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_valid (bus.i_valid),
        .i_sof   (bus.i_sof),
        .x       (w_x),
        .y       (w_y),
        .last    (w_last)
    );

    assign w_new = bus.i_valid && bus.i_sof;
    assign w_pix = bus.i_valid && (bus.i_sof || (r_state == ACC));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = IDLE;
            ACC:     w_state_n = ACC;
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        if (w_new)
            w_state_n = ACC;
        if (w_pix && w_last)
            w_state_n = DONE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_state_n;
    end

    // Start of frame folds pixel (0,0) into freshly cleared accumulators
    always_comb begin
        w_cnt_base = w_new ? '0 : r_cnt;
        w_x_min_n  = w_new ? '0 : r_x_min;
        w_x_max_n  = w_new ? '0 : r_x_max;
        w_y_min_n  = w_new ? '0 : r_y_min;
        w_y_max_n  = w_new ? '0 : r_y_max;
        w_first    = (w_cnt_base == '0);
        w_cnt_n    = w_cnt_base;
        if (w_pix && bus.i_wb) begin
            w_cnt_n = w_cnt_base + (CNT_W+1)'(1);
            if (w_first) begin
                w_x_min_n = w_x;
                w_x_max_n = w_x;
                w_y_min_n = w_y;
                w_y_max_n = w_y;
            end else begin
                if (w_x < w_x_min_n) w_x_min_n = w_x;
                if (w_x > w_x_max_n) w_x_max_n = w_x;
                if (w_y < w_y_min_n) w_y_min_n = w_y;
                if (w_y > w_y_max_n) w_y_max_n = w_y;
            end
        end
    end

    assign w_cnt_sat = w_cnt_n[CNT_W] ? '1 : w_cnt_n[CNT_W-1:0];
    assign w_found   = (32'(w_cnt_n) >= c_MIN_PIX);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt   <= '0;
            r_x_min <= '0;
            r_x_max <= '0;
            r_y_min <= '0;
            r_y_max <= '0;
        end else if (w_pix) begin
            r_cnt   <= w_cnt_n;
            r_x_min <= w_x_min_n;
            r_x_max <= w_x_max_n;
            r_y_min <= w_y_min_n;
            r_y_max <= w_y_max_n;
        end
    end

    // Results latch as the last pixel is taken so they are live during DONE
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_res_x_min <= '0;
            r_res_x_max <= '0;
            r_res_y_min <= '0;
            r_res_y_max <= '0;
            r_res_cnt   <= '0;
            r_res_found <= 1'b0;
        end else if (w_pix && w_last) begin
            r_res_x_min <= w_x_min_n;
            r_res_x_max <= w_x_max_n;
            r_res_y_min <= w_y_min_n;
            r_res_y_max <= w_y_max_n;
            r_res_cnt   <= w_cnt_sat;
            r_res_found <= w_found;
        end
    end

    assign bus.o_box_valid = (r_state == DONE);
    assign bus.o_x_min     = r_res_x_min;
    assign bus.o_x_max     = r_res_x_max;
    assign bus.o_y_min     = r_res_y_min;
    assign bus.o_y_max     = r_res_y_max;
    assign bus.o_cnt       = r_res_cnt;
    assign bus.o_found     = r_res_found;

`ifdef COLOR_MASK_CENTROID_EN
    logic [XS_W-1:0] r_x_sum, w_x_sum_n, r_res_x_sum;
    logic [YS_W-1:0] r_y_sum, w_y_sum_n, r_res_y_sum;

    always_comb begin
        w_x_sum_n = w_new ? '0 : r_x_sum;
        w_y_sum_n = w_new ? '0 : r_y_sum;
        if (w_pix && bus.i_wb) begin
            w_x_sum_n = w_x_sum_n + XS_W'(w_x);
            w_y_sum_n = w_y_sum_n + YS_W'(w_y);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_x_sum     <= '0;
            r_y_sum     <= '0;
            r_res_x_sum <= '0;
            r_res_y_sum <= '0;
        end else begin
            if (w_pix) begin
                r_x_sum <= w_x_sum_n;
                r_y_sum <= w_y_sum_n;
            end
            if (w_pix && w_last) begin
                r_res_x_sum <= w_x_sum_n;
                r_res_y_sum <= w_y_sum_n;
            end
        end
    end

    assign bus.o_x_sum = r_res_x_sum;
    assign bus.o_y_sum = r_res_y_sum;
`else
    assign bus.o_x_sum = '0;
    assign bus.o_y_sum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_color_mask_bbox.sv
// ============================================================================
// Module : tb_color_mask_bbox
// Brief  : Directed and randomised frames against a whole-frame mask model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_color_mask_bbox;

    localparam int IMG_W   = 8;
    localparam int IMG_H   = 4;
    localparam int MIN_PIX = 3;

    typedef struct {
        logic [31:0] x_min, x_max, y_min, y_max, cnt, found, x_sum, y_sum, lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_mask_bbox_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    color_mask_bbox #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .MIN_PIX (MIN_PIX)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    bit   mask [IMG_H][IMG_W];
    res_t got_q[$];
    res_t exp_q[$];
    res_t last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_box_valid === 1'b1) begin
            res_t r;
            r.x_min = 32'(bus.o_x_min);
            r.x_max = 32'(bus.o_x_max);
            r.y_min = 32'(bus.o_y_min);
            r.y_max = 32'(bus.o_y_max);
            r.cnt   = 32'(bus.o_cnt);
            r.found = 32'(bus.o_found);
            r.x_sum = 32'(bus.o_x_sum);
            r.y_sum = 32'(bus.o_y_sum);
            r.lat   = 32'(cyc - last_edge + 1);
            got_q.push_back(r);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-frame reference: scan the mask image directly
    function automatic res_t model();
        res_t r;
        int n = 0, xmn = IMG_W, xmx = -1, ymn = IMG_H, ymx = -1, xs = 0, ys = 0;
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++)
                if (mask[yy][xx]) begin
                    n++;
                    xs += xx;
                    ys += yy;
                    if (xx < xmn) xmn = xx;
                    if (xx > xmx) xmx = xx;
                    if (yy < ymn) ymn = yy;
                    if (yy > ymx) ymx = yy;
                end
        if (n == 0) begin
            xmn = 0; xmx = 0; ymn = 0; ymx = 0;
        end
        r.x_min = 32'(xmn); r.x_max = 32'(xmx);
        r.y_min = 32'(ymn); r.y_max = 32'(ymx);
        r.cnt   = 32'(n);
        r.found = (n >= MIN_PIX) ? 32'd1 : 32'd0;
`ifdef COLOR_MASK_CENTROID_EN
        r.x_sum = 32'(xs); r.y_sum = 32'(ys);
`else
        r.x_sum = 32'd0;   r.y_sum = 32'd0;
`endif
        r.lat = 32'd1;
        return r;
    endfunction

    task automatic drive(input bit sof, input bit wb);
        bus.i_valid = 1'b1; bus.i_sof = sof; bus.i_wb = wb;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_wb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mask();
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++) mask[yy][xx] = 1'b0;
    endtask

    task automatic rand_mask();
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++) mask[yy][xx] = ($urandom_range(2, 0) == 0);
        mask[$urandom_range(IMG_H-1, 0)][$urandom_range(IMG_W-1, 0)] = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++) begin
                drive(xx == 0 && yy == 0, mask[yy][xx]);
                if (gap_max > 0 && !(xx == IMG_W-1 && yy == IMG_H-1))
                    idle($urandom_range(gap_max, 0));
            end
        last_edge = cyc;
        last_exp  = model();
        exp_q.push_back(last_exp);
    endtask

    task automatic check_held(input string tag);
        chk({tag, "/hold_xmin"}, 32'(bus.o_x_min), last_exp.x_min);
        chk({tag, "/hold_xmax"}, 32'(bus.o_x_max), last_exp.x_max);
        chk({tag, "/hold_ymin"}, 32'(bus.o_y_min), last_exp.y_min);
        chk({tag, "/hold_ymax"}, 32'(bus.o_y_max), last_exp.y_max);
        chk({tag, "/hold_cnt"},  32'(bus.o_cnt),   last_exp.cnt);
        chk({tag, "/hold_xsum"}, 32'(bus.o_x_sum), last_exp.x_sum);
        chk({tag, "/hold_valid"}, 32'(bus.o_box_valid), 32'd0);
    endtask

    task automatic compare(input string tag);
        res_t g, e;
        idle(3);
        chk({tag, "/pulses"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "/x_min"}, g.x_min, e.x_min);
            chk({tag, "/x_max"}, g.x_max, e.x_max);
            chk({tag, "/y_min"}, g.y_min, e.y_min);
            chk({tag, "/y_max"}, g.y_max, e.y_max);
            chk({tag, "/cnt"},   g.cnt,   e.cnt);
            chk({tag, "/found"}, g.found, e.found);
            chk({tag, "/x_sum"}, g.x_sum, e.x_sum);
            chk({tag, "/y_sum"}, g.y_sum, e.y_sum);
            chk({tag, "/latency"}, g.lat, e.lat);
        end
        got_q.delete();
        exp_q.delete();
        check_held(tag);
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_wb = 1'b0;
        rst = 1'b1;
        idle(3);
        chk("rst/valid", 32'(bus.o_box_valid), 32'd0);
        chk("rst/x_max", 32'(bus.o_x_max), 32'd0);
        chk("rst/y_max", 32'(bus.o_y_max), 32'd0);
        chk("rst/cnt",   32'(bus.o_cnt),   32'd0);
        chk("rst/found", 32'(bus.o_found), 32'd0);
        chk("rst/sums",  32'(bus.o_x_sum) | 32'(bus.o_y_sum), 32'd0);
        rst = 1'b0;
        idle(2);

        // Three-pixel reference frame, plus literal spot values
        clear_mask();
        mask[1][2] = 1'b1; mask[1][5] = 1'b1; mask[2][3] = 1'b1;
        send_frame(0);
        idle(1);
        chk("ref/lit_xmin", 32'(bus.o_x_min), 32'd2);
        chk("ref/lit_xmax", 32'(bus.o_x_max), 32'd5);
        chk("ref/lit_ymin", 32'(bus.o_y_min), 32'd1);
        chk("ref/lit_ymax", 32'(bus.o_y_max), 32'd2);
        chk("ref/lit_cnt",  32'(bus.o_cnt),   32'd3);
        chk("ref/lit_found", 32'(bus.o_found), 32'd1);
`ifdef COLOR_MASK_CENTROID_EN
        chk("ref/lit_xsum", 32'(bus.o_x_sum), 32'd10);
        chk("ref/lit_ysum", 32'(bus.o_y_sum), 32'd4);
`else
        chk("ref/lit_xsum", 32'(bus.o_x_sum), 32'd0);
        chk("ref/lit_ysum", 32'(bus.o_y_sum), 32'd0);
`endif
        compare("ref");

        clear_mask();
        send_frame(0);
        compare("zero");

        // Short frame of 10 pixels, then a full frame
        drive(1'b1, 1'b1);
        repeat (9) drive(1'b0, 1'(($urandom_range(1, 0))));
        rand_mask();
        send_frame(0);
        compare("short");

        // Reset at pixel 20, then 15 more pixels with no sof
        drive(1'b1, 1'b1);
        repeat (19) drive(1'b0, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst/cnt",   32'(bus.o_cnt),   32'd0);
        chk("midrst/x_max", 32'(bus.o_x_max), 32'd0);
        repeat (15) drive(1'b0, 1'b1);
        last_exp = '{default: 32'd0};
        compare("midrst");
        rand_mask();
        send_frame(0);
        compare("postrst");

        // Single corner pixel with gaps, held outputs, then ignored tail pixels
        clear_mask();
        mask[3][7] = 1'b1;
        send_frame(3);
        compare("single");
        idle(10);
        check_held("single_late");
        repeat (5) drive(1'b0, 1'b1);
        compare("tail");

        // Next sof lands on the DONE cycle
        rand_mask();
        send_frame(0);
        rand_mask();
        send_frame(1);
        compare("b2b");

        for (int k = 0; k < 6; k++) begin
            rand_mask();
            send_frame(k % 3);
            compare("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/color_mask_bbox.md
COLOR_MASK_BBOX -- requirements
Module: color_mask_bbox

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter MIN_PIX, default 64, meaning the minimum number of mask pixels needed to assert o_found.
REQ-004 SHALL have localparams X_W=$clog2(IMG_W), Y_W=$clog2(IMG_H) and CNT_W=X_W+Y_W.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: synchronous reset, active-high.
REQ-007 SHALL have port i_valid, input, 1 bit: pixel strobe from the colour-classification stage.
REQ-008 SHALL have port i_sof, input, 1 bit: start-of-frame, asserted together with i_valid on pixel (0,0).
REQ-009 SHALL have port i_wb, input, 1 bit: target-colour mask bit for the current pixel.
REQ-010 SHALL have port o_box_valid, output, 1 bit: one-cycle pulse when a frame result is presented.
REQ-011 SHALL have ports o_x_min and o_x_max, output, X_W bits each, plus o_y_min and o_y_max, output, Y_W bits each: bounding box of the mask pixels.
REQ-012 SHALL have port o_cnt, output, CNT_W bits: number of mask pixels in the frame.
REQ-013 SHALL have port o_found, output, 1 bit: high when o_cnt >= MIN_PIX.
REQ-014 SHALL have ports o_x_sum and o_y_sum, output, X_W+CNT_W and Y_W+CNT_W bits: coordinate sums for a downstream centroid.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACC and DONE.
REQ-016 SHALL treat i_valid&i_sof in any state as pixel (0,0) of a new frame:
- clear counters and accumulators, then fold in this pixel;
- go to ACC.
REQ-017 SHALL ignore i_valid without i_sof while in IDLE.
REQ-018 SHALL handle each i_valid pixel in ACC as follows:
- counter x increments;
- at x=IMG_W-1, x wraps to 0 and y increments;
- if i_wb=1, update min/max, increment the count and add to the sums.
REQ-019 SHALL, on the first mask pixel of a frame, load both min and max of each axis with that pixel's coordinate.
REQ-020 SHALL enter DONE on the cycle after pixel (IMG_W-1, IMG_H-1) is accepted, and return to IDLE after one cycle.
REQ-021 SHALL, in DONE:
- drive o_box_valid=1 for exactly one cycle;
- register the result outputs and hold them until the next DONE.
REQ-022 SHALL have a latency of exactly 1 clock from the last pixel to o_box_valid.
REQ-023 SHALL, when a frame contains zero mask pixels, present all box outputs, o_cnt and the sums as 0, with o_found=0.
REQ-024 SHALL, on i_sof during ACC (short frame), discard the partial frame with no o_box_valid pulse and start the new frame.
REQ-025 SHALL, when i_sof coincides with DONE, still pulse o_box_valid for the completed frame while the new frame starts accumulating.
REQ-026 SHALL ignore i_valid pixels after the last pixel and before the next i_sof.
REQ-027 SHALL size the count and sums so they cannot overflow for IMG_W*IMG_H pixels.

Reset
REQ-028 SHALL, while sys_rst=1 at a clock edge, set the FSM to IDLE, clear all counters and accumulators, and drive every output to 0.
REQ-029 SHALL, on reset mid-frame, abandon the frame without a pulse; accumulation resumes only at the next i_sof.

Configuration
REQ-030 SHALL, with macro COLOR_MASK_CENTROID_EN defined, implement the sum accumulators and drive o_x_sum/o_y_sum with the frame results.
REQ-031 SHALL, without COLOR_MASK_CENTROID_EN, omit the accumulators and tie o_x_sum/o_y_sum to 0; all other behaviour is identical.

Structure
REQ-032 SHALL place the default IMG_W/IMG_H values and the macro name in the shared define file, next to COLOR_WIDTH.
REQ-033 SHALL implement the x/y raster counter as sub-module pix_xy_cnt with inputs i_valid and i_sof and outputs x, y and last.
REQ-034 SHALL keep the FSM, min/max logic and accumulators in color_mask_bbox.

Verification (IMG_W=8, IMG_H=4, MIN_PIX=3, macro defined)
REQ-035 SHALL cover: mask pixels at (2,1), (5,1) and (3,2) -> one pulse 1 clock after the pixel (7,3) strobe with x_min=2, x_max=5, y_min=1, y_max=2, cnt=3, found=1, x_sum=10, y_sum=4.
REQ-036 SHALL cover: an all-zero mask -> pulse with all outputs 0 and found=0.
REQ-037 SHALL cover: i_sof reasserted after 10 pixels -> no pulse; the next full frame reports only its own pixels.
REQ-038 SHALL cover: sys_rst pulsed at pixel 20, then 15 more valid pixels -> no pulse; the next frame after i_sof reports correctly.
REQ-039 SHALL cover: a single mask pixel at (7,3) with i_valid gaps between pixels -> x_min=x_max=7, y_min=y_max=3, cnt=1, found=0, with outputs held until the next pulse.
REQ-040 SHALL cover: the macro undefined with the stimulus of REQ-035 -> identical box/count results, with o_x_sum=o_y_sum=0.
